// File: rtl/lcs_mul_pkg.sv
// lcs_mul_pkg: shared widths and types for the multiplier accumulate/resolve datapath
package lcs_mul_pkg;
  localparam int COL_W = 20;
  localparam int DIGIT_W = 16;
  localparam int CARRY_W = 6;
  localparam int NCOL_PP = 130;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cs_lane.sv
// cs_lane: one column of the carry resolver, digit = low 16 bits of c+s+cin, cout = the rest
//   c, s  : carry-save column pair (weight 2^(16i))
//   cin   : carry from the column below
//   digit : normalized radix-2^16 digit
//   cout  : carry into the column above (at most 32, so 6 bits never truncate)
module cs_lane
  import lcs_mul_pkg::*;
(
  input  logic [COL_W-1:0]   c,
  input  logic [COL_W-1:0]   s,
  input  logic [CARRY_W-1:0] cin,
  output logic [DIGIT_W-1:0] digit,
  output logic [CARRY_W-1:0] cout
);
  logic [DIGIT_W+CARRY_W-1:0] t;
  assign t = (DIGIT_W+CARRY_W)'(c) + (DIGIT_W+CARRY_W)'(s) + (DIGIT_W+CARRY_W)'(cin);
  assign digit = t[DIGIT_W-1:0];
  assign cout = t[DIGIT_W+CARRY_W-1:DIGIT_W];
endmodule

// File: rtl/cs_resolve_seq.sv
// cs_resolve_seq: sequential carry resolver turning carry-save columns into radix-2^16 digits
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : capture handshake for in_c/in_s (NCOL columns of 20 bits)
//   out_valid/out_ready  : result handshake for out_digits (NCOL x 16) and out_carry (6)
//   LANES columns are resolved per cycle; the working registers shift down by LANES columns
//   each cycle so the lanes always read the bottom slice, and digits shift in from the top.
module cs_resolve_seq
  import lcs_mul_pkg::*;
#(
  parameter int NCOL = NCOL_PP,
  parameter int LANES = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NCOL-1:0][COL_W-1:0]      in_c,
  input  logic [NCOL-1:0][COL_W-1:0]      in_s,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NCOL-1:0][DIGIT_W-1:0]    out_digits,
  output logic [CARRY_W-1:0]              out_carry
);
  localparam int NCYC = NCOL / LANES;
  localparam int CNT_W = NCYC > 1 ? $clog2(NCYC) : 1;
  if (NCOL % LANES != 0) begin : g_bad_lanes
    $error("cs_resolve_seq: NCOL must be a multiple of LANES");
  end
  state_e state;
  logic [CNT_W-1:0] cnt;
  logic [CARRY_W-1:0] carry;
  logic [NCOL-1:0][COL_W-1:0] wc, ws;
  logic [LANES:0][CARRY_W-1:0] ch;
  logic [LANES-1:0][DIGIT_W-1:0] ld;
  assign in_ready = state == IDLE;
  assign ch[0] = carry;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cs_lane u_lane (
      .c(wc[g]),
      .s(ws[g]),
      .cin(ch[g]),
      .digit(ld[g]),
      .cout(ch[g+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      carry <= '0;
      wc <= '0;
      ws <= '0;
      out_valid <= 1'b0;
      out_carry <= '0;
      out_digits <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          wc <= in_c;
          ws <= in_s;
          carry <= '0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          wc <= {{(LANES*COL_W){1'b0}}, wc[NCOL-1:LANES]};
          ws <= {{(LANES*COL_W){1'b0}}, ws[NCOL-1:LANES]};
          out_digits <= {ld, out_digits[NCOL-1:LANES]};
          carry <= ch[LANES];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NCYC - 1)) begin
            out_carry <= ch[LANES];
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
